computational_unit: RTL
=======================

// Module: computational_unit
// PURPOSE
//  Datapath stage directly downstream of instruction_decoder. Holds the register file
//  (x0, x1, y0, y1, r, m, i) and the o_reg output port. Drives the 4-bit data bus from
//  one source. Evaluates ALU instructions and produces zero_flag for program_sequencer.
//  All state changes on rising clk, gated by the decoder's one-hot reg_en strobes.
// PARAMETERS
//  DATA_W  4  data bus / register width; the multiplier product is 2*DATA_W bits
// PORTS
//  clk        in   1       system clock, rising edge
//  reset      in   1       asynchronous, active-high; clears all state
//  reg_en     in   9       load strobes: 0 x0,1 x1,2 y0,3 y1,4 r,5 m,6 i,7 dm,8 o_reg
//  source_sel in   4       data bus source: 0 x0,1 x1,2 y0,3 y1,4 r,5 m,6 i,7 dm_data,
//                          8 ir_nibble,9 i_pins; 10-15 drive 0
//  x_sel      in   1       ALU x operand: 0 x0, 1 x1
//  y_sel      in   1       ALU y operand: 0 y0, 1 y1
//  i_sel      in   1       i load source: 0 data_bus, 1 i+m (post-modify)
//  ir_nibble  in   DATA_W  immediate / ALU function code from decoder
//  i_pins     in   DATA_W  external input pins
//  dm_data    in   DATA_W  data memory read data
//  data_bus   out  DATA_W  current bus value; also the data memory write data
//  dm_addr    out  DATA_W  equals i
//  dm_we      out  1       equals reg_en[7], combinational
//  o_reg      out  DATA_W  output port register
//  x0,x1,y0,y1,r,m,i out DATA_W  register contents, for debug
//  zero_flag  out  1       1 when the last executed ALU result was zero
//  from_CU    out  8       debug: {data_bus, ir_nibble[2:0], zero_flag}
// BEHAVIOUR
//  - Reset (async assert): every register, o_reg and zero_flag go to 0; held at 0 while
//    reset is high. Release is synchronous to the next rising clk.
//  - data_bus: combinational mux on source_sel. Sources are register outputs, so a
//    register read and load in the same cycle read the old value, e.g. r<=f(r).
//  - x0/x1/y0/y1/m/o_reg: when the matching reg_en bit is set, load data_bus on the
//    edge. Latency 1 cycle.
//  - i: when reg_en[6] is set, load data_bus if i_sel=0, else load (i+m) mod 2^DATA_W.
//    Wrap-around is silent.
//  - ALU (reg_en[4]): x = x_sel?x1:x0 and y = y_sel?y1:y0. Function is ir_nibble[2:0],
//    with ir_nibble[3] qualifying codes 000 and 111. All arithmetic is mod 2^DATA_W.
//      000: -x if nib[3]=0, else NOP   001: x-y   010: x+y   011: (x*y)[2W-1:W]
//      100: (x*y)[W-1:0]   101: x^y   110: x&y   111: ~x if nib[3]=0, else NOP
//  - When r is loaded, zero_flag <= (result==0) on the same edge.
//  - A NOP leaves both r and zero_flag unchanged. When reg_en[4]=0, zero_flag holds.
//  - r is written only by the ALU. source_sel is don't-care during ALU instructions.
//  - Multiple reg_en bits set in one cycle: all selected registers load in parallel.
//    The decoder never does this, so the case is not checked.
//  - Reset mid-instruction: any pending load is lost; no partial update.
// STRUCTURE
//  - cu_pkg: source_sel codes (SRC_X0..SRC_IPINS), reg_en bit indices (EN_X0..EN_OREG),
//    ALU op enum alu_op_t.
//  - One sub-module, cu_alu: combinational. Inputs x, y, op, nib3; outputs result and
//    is_nop. The multiplier is a 2W-bit product.
//  - The top level holds the bus mux, register file, i post-modify adder and zero_flag.
// TESTING
//  1. Assert reset mid-run with x0=7, zero_flag=1 -> all registers and zero_flag read 0
//     immediately, before any clk edge.
//  2. source_sel=8, ir_nibble=5, reg_en[0] -> x0=5 after 1 edge; data_bus=5 that cycle.
//  3. x0=5, y0=3, op 010 -> r=8, zf=0. Then x0=3, y0=3, op 001 -> r=0, zf=1.
//     Then op 111 with nib[3]=1 -> r=0 and zf=1 unchanged.
//  4. x1=7, y1=9, x_sel=y_sel=1: op 011 -> r=3. op 100 -> r=F, zf=0.
//  5. i=E, m=3, i_sel=1, reg_en[6] -> i=1 (wrap); dm_addr=1 next cycle.
//  6. source_sel=4 with reg_en[8] in the same cycle as an ALU write to r -> o_reg gets
//     the old r. source_sel=12 -> data_bus=0.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared encodings for the computational unit: bus source codes, load strobe indices
// and ALU function codes.
package cu_pkg;

  localparam logic [3:0] SRC_X0    = 4'd0;
  localparam logic [3:0] SRC_X1    = 4'd1;
  localparam logic [3:0] SRC_Y0    = 4'd2;
  localparam logic [3:0] SRC_Y1    = 4'd3;
  localparam logic [3:0] SRC_R     = 4'd4;
  localparam logic [3:0] SRC_M     = 4'd5;
  localparam logic [3:0] SRC_I     = 4'd6;
  localparam logic [3:0] SRC_DM    = 4'd7;
  localparam logic [3:0] SRC_IR    = 4'd8;
  localparam logic [3:0] SRC_IPINS = 4'd9;

  localparam int unsigned EN_X0   = 0;
  localparam int unsigned EN_X1   = 1;
  localparam int unsigned EN_Y0   = 2;
  localparam int unsigned EN_Y1   = 3;
  localparam int unsigned EN_R    = 4;
  localparam int unsigned EN_M    = 5;
  localparam int unsigned EN_I    = 6;
  localparam int unsigned EN_DM   = 7;
  localparam int unsigned EN_OREG = 8;

  typedef enum logic [2:0] {
    AluNeg   = 3'b000,
    AluSub   = 3'b001,
    AluAdd   = 3'b010,
    AluMulHi = 3'b011,
    AluMulLo = 3'b100,
    AluXor   = 3'b101,
    AluAnd   = 3'b110,
    AluNot   = 3'b111
  } alu_op_t;

endpackage

// File: rtl/cu_alu.sv
// Combinational ALU; codes 000 and 111 become NOPs when nib3 is set.
module cu_alu
  import cu_pkg::*;
#(
  parameter int unsigned DATA_W = 4
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  alu_op_t           op,
  input  logic              nib3,
  output logic [DATA_W-1:0] result,
  output logic              is_nop
);

  logic [2*DATA_W-1:0] prod;
  assign prod = {{DATA_W{1'b0}}, x} * {{DATA_W{1'b0}}, y};

  always_comb begin
    result = '0;
    is_nop = 1'b0;
    case (op)
      AluNeg: begin
        result = '0 - x;
        is_nop = nib3;
      end
      AluSub:   result = x - y;
      AluAdd:   result = x + y;
      AluMulHi: result = prod[2*DATA_W-1:DATA_W];
      AluMulLo: result = prod[DATA_W-1:0];
      AluXor:   result = x ^ y;
      AluAnd:   result = x & y;
      AluNot: begin
        result = ~x;
        is_nop = nib3;
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/computational_unit.sv
// Datapath stage: register file, data bus mux, i post-modify, ALU result register and
// zero flag. All loads are gated by the decoder's one-hot reg_en strobes.
module computational_unit
  import cu_pkg::*;
#(
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [8:0]        reg_en,
  input  logic [3:0]        source_sel,
  input  logic              x_sel,
  input  logic              y_sel,
  input  logic              i_sel,
  input  logic [DATA_W-1:0] ir_nibble,
  input  logic [DATA_W-1:0] i_pins,
  input  logic [DATA_W-1:0] dm_data,
  output logic [DATA_W-1:0] data_bus,
  output logic [DATA_W-1:0] dm_addr,
  output logic              dm_we,
  output logic [DATA_W-1:0] o_reg,
  output logic [DATA_W-1:0] x0,
  output logic [DATA_W-1:0] x1,
  output logic [DATA_W-1:0] y0,
  output logic [DATA_W-1:0] y1,
  output logic [DATA_W-1:0] r,
  output logic [DATA_W-1:0] m,
  output logic [DATA_W-1:0] i,
  output logic              zero_flag,
  output logic [DATA_W+3:0] from_CU
);

  logic [DATA_W-1:0] x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
  logic [DATA_W-1:0] r_q, r_d, m_q, m_d, i_q, i_d, o_reg_q, o_reg_d;
  logic              zf_q, zf_d;
  logic [DATA_W-1:0] alu_x, alu_y, alu_result;
  logic              alu_nop;

  // Bus sources are register outputs, so same-cycle read+load sees the old value.
  always_comb begin
    data_bus = '0;
    case (source_sel)
      SRC_X0:    data_bus = x0_q;
      SRC_X1:    data_bus = x1_q;
      SRC_Y0:    data_bus = y0_q;
      SRC_Y1:    data_bus = y1_q;
      SRC_R:     data_bus = r_q;
      SRC_M:     data_bus = m_q;
      SRC_I:     data_bus = i_q;
      SRC_DM:    data_bus = dm_data;
      SRC_IR:    data_bus = ir_nibble;
      SRC_IPINS: data_bus = i_pins;
      default:   data_bus = '0;
    endcase
  end

  assign alu_x = x_sel ? x1_q : x0_q;
  assign alu_y = y_sel ? y1_q : y0_q;

  cu_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .x     (alu_x),
    .y     (alu_y),
    .op    (alu_op_t'(ir_nibble[2:0])),
    .nib3  (ir_nibble[3]),
    .result(alu_result),
    .is_nop(alu_nop)
  );

  always_comb begin
    x0_d    = reg_en[EN_X0] ? data_bus : x0_q;
    x1_d    = reg_en[EN_X1] ? data_bus : x1_q;
    y0_d    = reg_en[EN_Y0] ? data_bus : y0_q;
    y1_d    = reg_en[EN_Y1] ? data_bus : y1_q;
    m_d     = reg_en[EN_M] ? data_bus : m_q;
    o_reg_d = reg_en[EN_OREG] ? data_bus : o_reg_q;
    i_d     = i_q;
    if (reg_en[EN_I]) begin
      i_d = i_sel ? (i_q + m_q) : data_bus;
    end
    r_d  = r_q;
    zf_d = zf_q;
    if (reg_en[EN_R] && !alu_nop) begin
      r_d  = alu_result;
      zf_d = (alu_result == '0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x0_q    <= '0;
      x1_q    <= '0;
      y0_q    <= '0;
      y1_q    <= '0;
      r_q     <= '0;
      m_q     <= '0;
      i_q     <= '0;
      o_reg_q <= '0;
      zf_q    <= 1'b0;
    end else begin
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      r_q     <= r_d;
      m_q     <= m_d;
      i_q     <= i_d;
      o_reg_q <= o_reg_d;
      zf_q    <= zf_d;
    end
  end

  assign x0        = x0_q;
  assign x1        = x1_q;
  assign y0        = y0_q;
  assign y1        = y1_q;
  assign r         = r_q;
  assign m         = m_q;
  assign i         = i_q;
  assign o_reg     = o_reg_q;
  assign zero_flag = zf_q;
  assign dm_addr   = i_q;
  assign dm_we     = reg_en[EN_DM];
  assign from_CU   = {data_bus, ir_nibble[2:0], zf_q};

endmodule
